// File: rtl/noc_pkg.sv
// Shared types for the master-0 AXI write packetizer: flit layout and FSM states.
package noc_pkg;

  localparam int unsigned FLIT_W = 38;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned RESP_W = 2;

  // Flit type field, flit_data[37:36]
  typedef enum logic [1:0] {
    FT_HEAD = 2'b00,
    FT_BODY = 2'b01,
    FT_TAIL = 2'b10
  } flit_type_e;

  // Head flit payload, flit_data[35:0]
  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [3:0]  id;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [14:0] rsvd;
  } head_payload_t;

  // Data flit payload, flit_data[35:0]
  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
  } data_payload_t;

  // Packetizer sequencing
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAD = 2'b01,
    ST_ADDR = 2'b10,
    ST_DATA = 2'b11
  } state_e;

endpackage

// File: rtl/noc_bresp_reg.sv
// One-entry B response register between the NoC response channel and AXI B.
module noc_bresp_reg
  import noc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [ID_W-1:0]   i_rsp_id,
  input  logic [RESP_W-1:0] i_rsp_resp,
  input  logic              i_rsp_valid,
  output logic              o_rsp_ready,
  output logic [ID_W-1:0]   o_bid,
  output logic [RESP_W-1:0] o_bresp,
  output logic              o_bvalid,
  input  logic              i_bready
);

  logic              r_bvalid;
  logic [ID_W-1:0]   r_bid;
  logic [RESP_W-1:0] r_bresp;
  logic              w_rsp_hs;

  // Accept a response when empty or when the held one leaves this cycle
  assign o_rsp_ready = i_en && (!r_bvalid || i_bready);
  assign w_rsp_hs    = i_rsp_valid && o_rsp_ready;

  assign o_bvalid = r_bvalid;
  assign o_bid    = r_bid;
  assign o_bresp  = r_bresp;

  // Load on response handshake, drain on BREADY, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bvalid <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= '0;
    end else if (w_rsp_hs) begin
      r_bvalid <= 1'b1;
      r_bid    <= i_rsp_id;
      r_bresp  <= i_rsp_resp;
    end else if (i_bready) begin
      r_bvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/m0_axi_wr_packetizer.sv
// Serialises master-0 AXI4 write bursts into NoC packets (head, address, data
// flits) and returns NoC write responses on the B channel.
module m0_axi_wr_packetizer
  import noc_pkg::*;
#(
  parameter logic [3:0]  SRC_ID    = 4'd0,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned DEST_LSB  = 28
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [3:0]        M0_AWID,
  input  logic [31:0]       M0_AWADDR,
  input  logic [3:0]        M0_AWLEN,
  input  logic [2:0]        M0_AWSIZE,
  input  logic [1:0]        M0_AWBURST,
  input  logic              M0_AWVALID,
  output logic              M0_AWREADY,
  input  logic [31:0]       M0_WDATA,
  input  logic [3:0]        M0_WSTRB,
  input  logic              M0_WLAST,
  input  logic              M0_WVALID,
  output logic              M0_WREADY,
  output logic [3:0]        M0_BID,
  output logic [1:0]        M0_BRESP,
  output logic              M0_BVALID,
  input  logic              M0_BREADY,
  output logic [FLIT_W-1:0] flit_data,
  output logic              flit_valid,
  input  logic              flit_ready,
  input  logic [3:0]        rsp_id,
  input  logic [1:0]        rsp_resp,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  output logic              wlast_err,
  output logic [3:0]        outst_cnt
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  state_e        r_state;
  logic          r_run;
  logic [3:0]    r_id;
  logic [31:0]   r_addr;
  logic [3:0]    r_len;
  logic [2:0]    r_size;
  logic [1:0]    r_burst;
  logic [3:0]    r_beat;
  logic [3:0]    r_cnt;
  logic          r_wlast_err;

  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_b_hs;
  logic          w_last_beat;
  flit_type_e    w_dtype;
  head_payload_t w_head;
  data_payload_t w_dpay;

  assign w_aw_hs     = M0_AWVALID && M0_AWREADY;
  assign w_w_hs      = M0_WVALID && M0_WREADY;
  assign w_b_hs      = M0_BVALID && M0_BREADY;
  assign w_last_beat = (r_beat == r_len);
  assign w_dtype     = w_last_beat ? FT_TAIL : FT_BODY;
  assign outst_cnt   = r_cnt;
  assign wlast_err   = r_wlast_err;

  // Head and data payloads from latched AW fields and the live W beat
  always_comb begin
    w_head       = '0;
    w_head.dest  = r_addr[DEST_LSB +: 4];
    w_head.src   = SRC_ID;
    w_head.id    = r_id;
    w_head.len   = r_len;
    w_head.size  = r_size;
    w_head.burst = r_burst;
    w_dpay       = '0;
    w_dpay.strb  = M0_WSTRB;
    w_dpay.data  = M0_WDATA;
  end

  // Handshake signals and flit mux; W passes straight through in DATA
  always_comb begin
    M0_AWREADY = 1'b0;
    M0_WREADY  = 1'b0;
    flit_valid = 1'b0;
    flit_data  = '0;
    case (r_state)
      ST_IDLE: M0_AWREADY = r_run && (r_cnt < MAX_CNT);
      ST_HEAD: begin
        flit_valid = 1'b1;
        flit_data  = {FT_HEAD, w_head};
      end
      ST_ADDR: begin
        flit_valid = 1'b1;
        flit_data  = {FT_BODY, 4'h0, r_addr};
      end
      ST_DATA: begin
        flit_valid = M0_WVALID;
        M0_WREADY  = flit_ready;
        flit_data  = {w_dtype, w_dpay};
      end
      default: ;
    endcase
  end

  // Ready qualifier: keeps AWREADY and rsp_ready low while in reset
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_run <= 1'b0;
    else          r_run <= 1'b1;
  end

  // Packet sequencer and AW field latch
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs) begin
            r_id    <= M0_AWID;
            r_addr  <= M0_AWADDR;
            r_len   <= M0_AWLEN;
            r_size  <= M0_AWSIZE;
            r_burst <= M0_AWBURST;
            r_beat  <= '0;
            r_state <= ST_HEAD;
          end
        end
        ST_HEAD: if (flit_ready) r_state <= ST_ADDR;
        ST_ADDR: if (flit_ready) r_state <= ST_DATA;
        ST_DATA: begin
          if (w_w_hs) begin
            r_beat <= r_beat + 4'd1;
            if (w_last_beat) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding-write counter; a stray B at zero is ignored
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_cnt <= '0;
    end else begin
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_cnt <= r_cnt + 4'd1;
        2'b01:   if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        2'b11:   if (r_cnt == 4'd0) r_cnt <= 4'd1;
        default: ;
      endcase
    end
  end

  // Sticky protocol error: WLAST misplaced, or B with nothing outstanding
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wlast_err <= 1'b0;
    end else begin
      if (w_w_hs && (M0_WLAST != w_last_beat)) r_wlast_err <= 1'b1;
      if (w_b_hs && (r_cnt == 4'd0))           r_wlast_err <= 1'b1;
    end
  end

  // B channel register
  noc_bresp_reg u_bresp (
    .clk         (ACLK),
    .rst_n       (ARESETn),
    .i_en        (r_run),
    .i_rsp_id    (rsp_id),
    .i_rsp_resp  (rsp_resp),
    .i_rsp_valid (rsp_valid),
    .o_rsp_ready (rsp_ready),
    .o_bid       (M0_BID),
    .o_bresp     (M0_BRESP),
    .o_bvalid    (M0_BVALID),
    .i_bready    (M0_BREADY)
  );

endmodule

// File: tb/tb_m0_axi_wr_packetizer.sv
// Bench for m0_axi_wr_packetizer: randomized bursts against a packet-level model.
module tb_m0_axi_wr_packetizer;

  localparam logic [3:0] SRC = 4'h9;

  logic        ACLK, ARESETn;
  logic [3:0]  M0_AWID;
  logic [31:0] M0_AWADDR;
  logic [3:0]  M0_AWLEN;
  logic [2:0]  M0_AWSIZE;
  logic [1:0]  M0_AWBURST;
  logic        M0_AWVALID, M0_AWREADY;
  logic [31:0] M0_WDATA;
  logic [3:0]  M0_WSTRB;
  logic        M0_WLAST, M0_WVALID, M0_WREADY;
  logic [3:0]  M0_BID;
  logic [1:0]  M0_BRESP;
  logic        M0_BVALID, M0_BREADY;
  logic [37:0] flit_data;
  logic        flit_valid, flit_ready;
  logic [3:0]  rsp_id;
  logic [1:0]  rsp_resp;
  logic        rsp_valid, rsp_ready;
  logic        wlast_err;
  logic [3:0]  outst_cnt;

  m0_axi_wr_packetizer #(.SRC_ID(SRC), .MAX_OUTST(2), .DEST_LSB(28)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M0_AWID(M0_AWID), .M0_AWADDR(M0_AWADDR), .M0_AWLEN(M0_AWLEN),
    .M0_AWSIZE(M0_AWSIZE), .M0_AWBURST(M0_AWBURST),
    .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY),
    .M0_WDATA(M0_WDATA), .M0_WSTRB(M0_WSTRB), .M0_WLAST(M0_WLAST),
    .M0_WVALID(M0_WVALID), .M0_WREADY(M0_WREADY),
    .M0_BID(M0_BID), .M0_BRESP(M0_BRESP), .M0_BVALID(M0_BVALID), .M0_BREADY(M0_BREADY),
    .flit_data(flit_data), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .rsp_id(rsp_id), .rsp_resp(rsp_resp), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .wlast_err(wlast_err), .outst_cnt(outst_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Flit monitor: records accepted flits and flags any stalled flit that changes
  logic [37:0] got_q[$];
  int          got_cyc[$];
  int          stab_err = 0;
  logic        mon_stall = 1'b0;
  logic [37:0] mon_data = '0;
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      mon_stall <= 1'b0;
    end else begin
      if (mon_stall && (!flit_valid || flit_data !== mon_data)) stab_err <= stab_err + 1;
      if (flit_valid && flit_ready) begin
        got_q.push_back(flit_data);
        got_cyc.push_back(cyc);
      end
      mon_stall <= flit_valid && !flit_ready;
      mon_data  <= flit_data;
    end
  end

  int          checks = 0;
  int          passes = 0;
  int          model_outst = 0;
  int          rd_idx = 0;
  int          aw_cyc = 0;
  logic        bp_on = 1'b0;
  logic [37:0] exp_q[$];
  logic [3:0]  cur_id;
  logic [31:0] cur_addr;
  logic [3:0]  cur_len;
  logic [2:0]  cur_size;
  logic [1:0]  cur_burst;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic step();
    @(posedge ACLK);
    #1;
    if (bp_on) flit_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_burst(input logic [3:0] len);
    cur_id    = 4'($urandom);
    cur_addr  = $urandom;
    cur_len   = len;
    cur_size  = 3'($urandom_range(0, 2));
    cur_burst = 2'($urandom_range(0, 2));
    for (int i = 0; i < 16; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'($urandom);
    end
  endtask

  // Reference packet: head, address, one flit per beat with TAIL on the last
  task automatic build_expect();
    exp_q.push_back({2'b00, cur_addr[31:28], SRC, cur_id, cur_len, cur_size, cur_burst, 15'd0});
    exp_q.push_back({2'b01, 4'h0, cur_addr});
    for (int i = 0; i <= int'(cur_len); i++)
      exp_q.push_back({(i == int'(cur_len)) ? 2'b10 : 2'b01, ws[i], wd[i]});
  endtask

  task automatic do_aw();
    logic hs = 1'b0;
    M0_AWVALID = 1'b1; M0_AWID = cur_id; M0_AWADDR = cur_addr;
    M0_AWLEN = cur_len; M0_AWSIZE = cur_size; M0_AWBURST = cur_burst;
    for (int k = 0; k < 200 && !hs; k++) begin
      @(negedge ACLK);
      hs = M0_AWREADY;
      if (hs) aw_cyc = cyc;
      step();
    end
    M0_AWVALID = 1'b0;
    checks++;
    if (!hs) $display("FAIL aw_handshake got timeout exp accept");
    else begin passes++; model_outst++; end
  endtask

  task automatic do_w(input int stall_beat, input int err_beat, input int stop_beat);
    logic hs;
    for (int i = 0; i <= int'(cur_len); i++) begin
      if (i == stop_beat) return;
      M0_WVALID = 1'b1; M0_WDATA = wd[i]; M0_WSTRB = ws[i];
      M0_WLAST  = 1'((i == int'(cur_len)) ^ (i == err_beat));
      if (i == stall_beat) begin
        flit_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          @(negedge ACLK);
          checks++;
          if (M0_WREADY !== 1'b0) $display("FAIL stall_wready got %0b exp 0", M0_WREADY);
          else passes++;
          checks++;
          if (flit_valid !== 1'b1 || flit_data !== {2'b01, ws[i], wd[i]})
            $display("FAIL stall_flit got %0b/%h exp 1/%h", flit_valid, flit_data, {2'b01, ws[i], wd[i]});
          else passes++;
          step();
        end
        flit_ready = 1'b1;
      end
      hs = 1'b0;
      for (int k = 0; k < 200 && !hs; k++) begin
        @(negedge ACLK);
        hs = M0_WREADY;
        step();
      end
      checks++;
      if (!hs) $display("FAIL w_handshake beat %0d got timeout exp accept", i);
      else passes++;
    end
    M0_WVALID = 1'b0;
    M0_WLAST  = 1'b0;
  endtask

  task automatic check_packet(input string name);
    int n = got_q.size() - rd_idx;
    checks++;
    if (n != exp_q.size()) $display("FAIL %s_count got %0d exp %0d", name, n, exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd_idx + i < got_q.size()) begin
        checks++;
        if (got_q[rd_idx + i] !== exp_q[i])
          $display("FAIL %s_flit%0d got %h exp %h", name, i, got_q[rd_idx + i], exp_q[i]);
        else passes++;
      end
    end
    rd_idx = got_q.size();
    exp_q.delete();
    checks++;
    if (stab_err != 0) $display("FAIL %s_stable got %0d changes exp 0", name, stab_err);
    else passes++;
    checks++;
    if (outst_cnt !== 4'(model_outst)) $display("FAIL %s_outst got %0d exp %0d", name, outst_cnt, model_outst);
    else passes++;
  endtask

  task automatic send_rsp(input logic [3:0] id, input logic [1:0] resp);
    logic hs = 1'b0;
    rsp_valid = 1'b1; rsp_id = id; rsp_resp = resp;
    for (int k = 0; k < 50 && !hs; k++) begin
      @(negedge ACLK);
      hs = rsp_ready;
      step();
    end
    rsp_valid = 1'b0;
    checks++;
    if (!hs) $display("FAIL rsp_handshake got timeout exp accept");
    else passes++;
    if (hs && M0_BREADY) begin
      @(negedge ACLK);
      checks++;
      if ({M0_BVALID, M0_BID, M0_BRESP} !== {1'b1, id, resp})
        $display("FAIL b_out got %0b/%h/%0d exp 1/%h/%0d", M0_BVALID, M0_BID, M0_BRESP, id, resp);
      else passes++;
      step();
      if (model_outst > 0) model_outst--;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({M0_AWREADY, M0_WREADY, M0_BVALID, flit_valid, rsp_ready, wlast_err} !== 6'b0)
      $display("FAIL %s_flags got %b exp 000000", name,
               {M0_AWREADY, M0_WREADY, M0_BVALID, flit_valid, rsp_ready, wlast_err});
    else passes++;
    checks++;
    if ({M0_BID, M0_BRESP} !== 6'b0) $display("FAIL %s_b got %h/%0d exp 0/0", name, M0_BID, M0_BRESP);
    else passes++;
    checks++;
    if (flit_data !== 38'd0) $display("FAIL %s_flit_data got %h exp 0", name, flit_data);
    else passes++;
    checks++;
    if (outst_cnt !== 4'd0) $display("FAIL %s_outst got %0d exp 0", name, outst_cnt);
    else passes++;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    check_reset_outputs("reset");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    step();
    @(negedge ACLK);
    checks++;
    if (M0_AWREADY !== 1'b1) $display("FAIL reset_awready_after got %0b exp 1", M0_AWREADY);
    else passes++;
    step();
  endtask

  task automatic test_single_beat();
    int base = rd_idx;
    rand_burst(4'd0);
    cur_id = 4'd5; cur_addr = 32'h3000_0010; wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    build_expect();
    do_aw();
    do_w(-1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      if (base + i < got_cyc.size()) begin
        checks++;
        if (got_cyc[base + i] != aw_cyc + 1 + i)
          $display("FAIL single_timing%0d got cycle %0d exp %0d", i, got_cyc[base + i], aw_cyc + 1 + i);
        else passes++;
      end
    end
    check_packet("single");
    send_rsp(4'd5, 2'b00);
  endtask

  task automatic test_backpressure();
    rand_burst(4'd3);
    build_expect();
    do_aw();
    do_w(1, -1, -1);
    checks++;
    if (got_q.size() == 0 || got_q[got_q.size() - 1][37:36] !== 2'b10)
      $display("FAIL bp_last_type got %b exp 10", got_q.size() == 0 ? 2'bxx : got_q[got_q.size() - 1][37:36]);
    else passes++;
    check_packet("bp");
    send_rsp(4'($urandom), 2'($urandom));
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      rand_burst(4'($urandom_range(0, 15)));
      build_expect();
      bp_on = 1'b1;
      do_aw();
      do_w(-1, -1, -1);
      bp_on = 1'b0;
      flit_ready = 1'b1;
      check_packet("random");
      send_rsp(4'($urandom), 2'($urandom));
    end
    checks++;
    if (wlast_err !== 1'b0) $display("FAIL random_wlast_err got %0b exp 0", wlast_err);
    else passes++;
  endtask

  task automatic test_outst_limit();
    for (int n = 0; n < 2; n++) begin
      rand_burst(4'($urandom_range(0, 3)));
      build_expect();
      do_aw();
      do_w(-1, -1, -1);
      check_packet("outst_fill");
    end
    rand_burst(4'd1);
    build_expect();
    M0_AWVALID = 1'b1; M0_AWID = cur_id; M0_AWADDR = cur_addr;
    M0_AWLEN = cur_len; M0_AWSIZE = cur_size; M0_AWBURST = cur_burst;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      checks++;
      if (M0_AWREADY !== 1'b0 || outst_cnt !== 4'd2)
        $display("FAIL outst_stall got %0b/%0d exp 0/2", M0_AWREADY, outst_cnt);
      else passes++;
      step();
    end
    send_rsp(4'($urandom), 2'b00);
    @(negedge ACLK);
    checks++;
    if (M0_AWREADY !== 1'b1 || outst_cnt !== 4'd1)
      $display("FAIL outst_reenable got %0b/%0d exp 1/1", M0_AWREADY, outst_cnt);
    else passes++;
    step();
    M0_AWVALID = 1'b0;
    model_outst++;
    do_w(-1, -1, -1);
    check_packet("outst_third");
    send_rsp(4'($urandom), 2'b00);
    send_rsp(4'($urandom), 2'b00);
  endtask

  task automatic test_b_stall();
    rand_burst(4'd0);
    build_expect();
    do_aw();
    do_w(-1, -1, -1);
    check_packet("bstall_wr");
    M0_BREADY = 1'b0;
    send_rsp(4'd7, 2'b10);
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      checks++;
      if ({M0_BVALID, M0_BID, M0_BRESP, rsp_ready} !== {1'b1, 4'd7, 2'b10, 1'b0})
        $display("FAIL bstall_hold got %0b/%h/%0d/%0b exp 1/7/2/0", M0_BVALID, M0_BID, M0_BRESP, rsp_ready);
      else passes++;
      checks++;
      if (outst_cnt !== 4'd1) $display("FAIL bstall_outst got %0d exp 1", outst_cnt);
      else passes++;
      step();
    end
    M0_BREADY = 1'b1;
    step();
    model_outst--;
    @(negedge ACLK);
    checks++;
    if (M0_BVALID !== 1'b0 || outst_cnt !== 4'd0)
      $display("FAIL bstall_done got %0b/%0d exp 0/0", M0_BVALID, outst_cnt);
    else passes++;
    step();
  endtask

  task automatic test_wlast_err();
    checks++;
    if (wlast_err !== 1'b0) $display("FAIL wlast_pre got %0b exp 0", wlast_err);
    else passes++;
    rand_burst(4'd2);
    build_expect();
    do_aw();
    do_w(-1, 0, -1);
    check_packet("wlast");
    checks++;
    if (wlast_err !== 1'b1) $display("FAIL wlast_err got %0b exp 1", wlast_err);
    else passes++;
    send_rsp(4'($urandom), 2'b00);
  endtask

  task automatic test_reset_mid();
    rand_burst(4'd3);
    do_aw();
    do_w(-1, -1, 1);
    M0_WVALID = 1'b1; M0_WDATA = wd[1]; M0_WSTRB = ws[1]; M0_WLAST = 1'b0;
    flit_ready = 1'b0;
    #2;
    ARESETn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    M0_WVALID = 1'b0;
    model_outst = 0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    flit_ready = 1'b1;
    rd_idx = got_q.size();
    step();
    rand_burst(4'd0);
    build_expect();
    do_aw();
    do_w(-1, -1, -1);
    check_packet("after_reset");
    send_rsp(4'($urandom), 2'b00);
  endtask

  initial begin
    M0_AWID = '0; M0_AWADDR = '0; M0_AWLEN = '0; M0_AWSIZE = '0; M0_AWBURST = '0;
    M0_AWVALID = 1'b0; M0_WDATA = '0; M0_WSTRB = '0; M0_WLAST = 1'b0; M0_WVALID = 1'b0;
    M0_BREADY = 1'b1; flit_ready = 1'b1; rsp_id = '0; rsp_resp = '0; rsp_valid = 1'b0;
    ARESETn = 1'b0;
    test_reset();
    test_single_beat();
    test_backpressure();
    test_random();
    test_outst_limit();
    test_b_stall();
    test_wlast_err();
    test_reset_mid();
    repeat (3) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule

// File: doc/m0_axi_wr_packetizer.md
Name: m0_axi_wr_packetizer

Overview:
- Network-interface write stage directly downstream of the master-0 AXI4 port.
- Accepts AW/W bursts from master 0 and serialises each burst into one NoC packet: head flit, address flit, then one data flit per beat.
- Returns NoC write responses to master 0 on the B channel.
- Limits the number of outstanding writes.

Parameters:
- SRC_ID, 4'd0, source node ID inserted in every head flit.
- MAX_OUTST, 4, maximum number of writes accepted but not yet answered on B (1..15).
- DEST_LSB, 28, LSB of the 4-bit destination field taken from AWADDR[DEST_LSB+3:DEST_LSB].

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- M0_AWID  in  4; M0_AWADDR  in  32; M0_AWLEN  in  4; M0_AWSIZE  in  3; M0_AWBURST  in  2; M0_AWVALID  in  1; M0_AWREADY  out  1.
- M0_WDATA  in  32; M0_WSTRB  in  4; M0_WLAST  in  1; M0_WVALID  in  1; M0_WREADY  out  1.
- M0_BID  out  4; M0_BRESP  out  2; M0_BVALID  out  1; M0_BREADY  in  1.
- flit_data  out  38  NoC flit, [37:36] type, [35:0] payload.
- flit_valid  out  1; flit_ready  in  1.
- rsp_id  in  4; rsp_resp  in  2; rsp_valid  in  1; rsp_ready  out  1  NoC response channel.
- wlast_err  out  1  sticky protocol-error flag.
- outst_cnt  out  4  current outstanding count.

Behaviour:
- Reset: FSM=IDLE, M0_AWREADY=0 during reset, M0_WREADY=0, M0_BVALID=0, M0_BID=0, M0_BRESP=0, flit_valid=0, flit_data=0, rsp_ready=0 during reset, wlast_err=0, outst_cnt=0. Reset mid-packet drops the packet silently with no partial tail.
- Flit types: 2'b00 HEAD, 2'b01 BODY, 2'b10 TAIL. Packets are always at least 3 flits, so no single-flit type exists.
- HEAD payload: [35:32] dest, [31:28] SRC_ID, [27:24] AWID, [23:20] AWLEN, [19:17] AWSIZE, [16:15] AWBURST, [14:0] zero.
- ADDR flit: type BODY, payload {4'h0, AWADDR}.
- DATA flit: payload {WSTRB, WDATA}. Type is TAIL on beat AWLEN, else BODY.
- FSM: IDLE -> HEAD -> ADDR -> DATA -> IDLE.
  - IDLE: M0_AWREADY = (outst_cnt < MAX_OUTST). On AW handshake, latch the AW fields, clear beat_cnt, go to HEAD.
  - HEAD: flit_valid=1. On flit_ready go to ADDR.
  - ADDR: flit_valid=1. On flit_ready go to DATA.
  - DATA: flit_valid = M0_WVALID and M0_WREADY = flit_ready, both combinational pass-through. No W beat is buffered. Each handshake increments beat_cnt. On the handshake with beat_cnt==AWLEN, go to IDLE.
- M0_AWREADY=0 and M0_WREADY=0 outside the states above.
- A new AW is accepted only in IDLE, so there is one packet in flight on the flit port at a time.
- Latency: AW handshake in cycle N gives the head flit valid in cycle N+1. Minimum packet time is AWLEN+3 cycles with no backpressure.
- flit_data and flit_valid hold stable while flit_valid && !flit_ready.
- WLAST check: a beat with WLAST=1 before beat AWLEN, or WLAST=0 on beat AWLEN, sets wlast_err (sticky until reset). Packet length always follows AWLEN.
- B stage: single register.
  - rsp_ready = !M0_BVALID || M0_BREADY.
  - On a rsp handshake, load M0_BID/M0_BRESP from rsp_id/rsp_resp and set M0_BVALID.
  - M0_BVALID clears on M0_BREADY unless refilled in the same cycle.
  - Outputs hold stable while stalled.
- outst_cnt:
  - +1 on AW handshake, -1 on B handshake. Both in the same cycle leave it unchanged.
  - A B handshake at outst_cnt==0 does not underflow (stays 0) and sets wlast_err.
- A B handshake at outst_cnt==MAX_OUTST re-enables M0_AWREADY in the following cycle.

Decomposition:
- Package noc_pkg:
  - FLIT_W=38.
  - flit type enum (HEAD/BODY/TAIL).
  - packed structs for the head payload and data payload.
  - state enum for the FSM.
- One sub-module: noc_bresp_reg, the one-entry B skid register with rsp_ready/BVALID logic.

Test Plan:
- Single-beat write:
  - Stimulus: AWADDR=32'h3000_0010, AWID=5, AWLEN=0, WDATA=32'hDEADBEEF, WSTRB=4'hF, WLAST=1, flit_ready=1.
  - Required: flits HEAD (dest=3, id=5), BODY 4'h0_3000_0010, TAIL F_DEADBEEF on consecutive cycles starting 1 cycle after AW.
- 4-beat burst with backpressure:
  - Stimulus: AWLEN=3; flit_ready low for 2 cycles during beat 1.
  - Required: flit_data stable while stalled, M0_WREADY=0 while stalled, exactly 6 flits, last one TAIL.
- Outstanding limit:
  - Stimulus: MAX_OUTST=2, three back-to-back AWs with no responses.
  - Required: third AW stalls (M0_AWREADY=0, outst_cnt=2). One rsp with BREADY=1 accepts the third AW the following cycle.
- WLAST errors:
  - Stimulus: AWLEN=2 with WLAST=1 on beat 0.
  - Required: wlast_err=1, still 5 flits emitted.
- B stall:
  - Stimulus: rsp_id=7, rsp_resp=2'b10, BREADY=0 for 3 cycles.
  - Required: M0_BVALID=1, M0_BID=7, M0_BRESP=2'b10 held stable, rsp_ready=0. BREADY=1 completes the handshake and outst_cnt decrements.
- Reset mid-packet:
  - Stimulus: ARESETn low during DATA beat 1 of AWLEN=3.
  - Required: all outputs at reset values immediately. After release the next AW produces a clean HEAD flit, outst_cnt=1.
